// File: rtl/conv_encoder_framer.sv
`default_nettype none
// ============================================================================
// Module   : conv_encoder_framer
// Purpose  : Rate-1/2 feedforward convolutional encoder and framer with an
//            optional zero tail, feeding the Viterbi decoder symbol stream.
// Revision : 1.0  initial release
// ============================================================================
module conv_encoder_framer #(
   parameter int             K    = 5,
   parameter logic [K-1:0]   G0   = 5'b11111,
   parameter logic [K-1:0]   G1   = 5'b11011,
   parameter bit             TAIL = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] payload_len,
   input  logic       bit_in,
   input  logic       bit_valid,
   output logic       bit_ready,
   output logic [1:0] sym_out,
   output logic       sym_valid,
   input  logic       sym_ready,
   output logic       sym_last,
   output logic [7:0] sym_idx,
   output logic [7:0] frame_len,
   output logic       busy,
   output logic       frame_done,
   output logic       len_err
);

   localparam int         M        = K - 1;
   localparam logic [8:0] TAIL_LEN = TAIL ? 9'(M) : 9'd0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_FLUSH  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t       state;
   state_t       state_nxt;

   logic [M-1:0] st;
   logic [7:0]   plen;
   logic [7:0]   load_cnt;

   logic         slot_free;
   logic [8:0]   total;
   logic         start_ok;
   logic         start_acc;
   logic         start_rej;
   logic         load;
   logic         enc_bit;
   logic         done;
   logic [K-1:0] r;
   logic [1:0]   sym_nxt;
   logic [M-1:0] st_nxt;

   // Single-entry output register: a new symbol may load while the old drains.
   assign slot_free = !sym_valid || sym_ready;
   assign total     = {1'b0, payload_len} + TAIL_LEN;
   assign start_ok  = (payload_len != 8'd0) && (total <= 9'd255);

   assign r       = {st, enc_bit};
   assign sym_nxt = {^(r & G0), ^(r & G1)};
   assign st_nxt  = {st[M-2:0], enc_bit};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      bit_ready = 1'b0;
      load      = 1'b0;
      enc_bit   = 1'b0;
      start_acc = 1'b0;
      start_rej = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (start_ok) begin
                  start_acc = 1'b1;
                  state_nxt = S_DATA;
               end else begin
                  start_rej = 1'b1;
               end
            end
         end
         S_DATA: begin
            bit_ready = slot_free;
            if (bit_valid && slot_free) begin
               load    = 1'b1;
               enc_bit = bit_in;
               if (load_cnt == plen - 8'd1) begin
                  state_nxt = TAIL ? S_FLUSH : S_FINISH;
               end
            end
         end
         S_FLUSH: begin
            // Zero injection drives the shift register back to all-zero.
            if (slot_free) begin
               load = 1'b1;
               if (load_cnt == frame_len - 8'd1) begin
                  state_nxt = S_FINISH;
               end
            end
         end
         S_FINISH: begin
            if (sym_valid && sym_ready && sym_last) begin
               done      = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= '0;
         plen       <= 8'd0;
         load_cnt   <= 8'd0;
         sym_out    <= 2'b00;
         sym_valid  <= 1'b0;
         sym_last   <= 1'b0;
         sym_idx    <= 8'd0;
         frame_len  <= 8'd0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         len_err    <= 1'b0;
      end else begin
         frame_done <= done;
         len_err    <= start_rej;

         if (start_acc) begin
            st        <= '0;
            plen      <= payload_len;
            frame_len <= total[7:0];
            busy      <= 1'b1;
            load_cnt  <= 8'd0;
         end

         if (load) begin
            sym_out   <= sym_nxt;
            sym_valid <= 1'b1;
            sym_idx   <= load_cnt;
            sym_last  <= (load_cnt == frame_len - 8'd1);
            st        <= st_nxt;
            load_cnt  <= load_cnt + 8'd1;
         end else if (sym_valid && sym_ready) begin
            sym_valid <= 1'b0;
         end

         if (done) begin
            busy     <= 1'b0;
            sym_last <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_encoder_framer
// Purpose  : Scoreboard bench for conv_encoder_framer (K=5, G0=37, G1=33, tail).
// Revision : 1.0  initial release
// ============================================================================
module tb_conv_encoder_framer;

   localparam int           K    = 5;
   localparam logic [K-1:0] G0   = 5'b11111;
   localparam logic [K-1:0] G1   = 5'b11011;
   localparam bit           TAIL = 1'b1;
   localparam int           M    = K - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] payload_len = 8'd0;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       bit_ready;
   logic [1:0] sym_out;
   logic       sym_valid;
   logic       sym_ready = 1'b1;
   logic       sym_last;
   logic [7:0] sym_idx;
   logic [7:0] frame_len;
   logic       busy;
   logic       frame_done;
   logic       len_err;

   conv_encoder_framer #(.K(K), .G0(G0), .G1(G1), .TAIL(TAIL)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .payload_len (payload_len),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .bit_ready   (bit_ready),
      .sym_out     (sym_out),
      .sym_valid   (sym_valid),
      .sym_ready   (sym_ready),
      .sym_last    (sym_last),
      .sym_idx     (sym_idx),
      .frame_len   (frame_len),
      .busy        (busy),
      .frame_done  (frame_done),
      .len_err     (len_err)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   bit          u [0:511];
   logic [10:0] sb [$];
   int          hs_count = 0;
   bit          bp_on = 1'b0;
   bit          done_pending = 1'b0;
   bit          prev_stall = 1'b0;
   logic [1:0]  prev_sym;
   logic [7:0]  prev_idx;
   logic        prev_last;
   logic [10:0] mon_e;
   bit          ab;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Convolution over the payload history: r bit j is the bit seen j steps ago.
   function automatic logic [1:0] model_sym(input int t);
      logic p0;
      logic p1;
      p0 = 1'b0;
      p1 = 1'b0;
      for (int j = 0; j < K; j++) begin
         if (t - j >= 0) begin
            p0 = p0 ^ (G0[j] & u[t-j]);
            p1 = p1 ^ (G1[j] & u[t-j]);
         end
      end
      return {p0, p1};
   endfunction

   task automatic push_exp(input int t, input int total);
      sb.push_back({model_sym(t), 8'(t), (t == total - 1)});
   endtask

   task automatic clear_u();
      for (int i = 0; i < 512; i++) u[i] = 1'b0;
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_sym_valid"}, sym_valid, 0);
      check({pfx, "_sym_out"}, sym_out, 0);
      check({pfx, "_sym_idx"}, sym_idx, 0);
      check({pfx, "_sym_last"}, sym_last, 0);
      check({pfx, "_frame_len"}, frame_len, 0);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_frame_done"}, frame_done, 0);
      check({pfx, "_len_err"}, len_err, 0);
      check({pfx, "_bit_ready"}, bit_ready, 0);
   endtask

   always @(posedge clk) begin
      #1;
      sym_ready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      if (rst) begin
         done_pending = 1'b0;
         prev_stall   = 1'b0;
      end else begin
         check("frame_done", frame_done, done_pending);
         done_pending = 1'b0;
         if (prev_stall) begin
            check("hold_sym", sym_out, prev_sym);
            check("hold_idx", sym_idx, prev_idx);
            check("hold_last", sym_last, prev_last);
         end
         if (sym_valid && !sym_ready) check("ready_when_full", bit_ready, 0);
         if (!busy) check("ready_when_idle", bit_ready, 0);
         if (sym_valid && sym_ready) begin
            if (sb.size() == 0) begin
               check("sb_underflow", sb.size(), 1);
            end else begin
               mon_e = sb.pop_front();
               check("sym", sym_out, mon_e[10:9]);
               check("idx", sym_idx, mon_e[8:1]);
               check("last", sym_last, mon_e[0]);
               if (sym_last) done_pending = 1'b1;
               hs_count++;
            end
         end
         prev_stall = sym_valid && !sym_ready;
         prev_sym   = sym_out;
         prev_idx   = sym_idx;
         prev_last  = sym_last;
      end
   end

   task automatic run_frame(input int len, input int abort_after, input bit poke, output bit aborted);
      int total;
      int i;
      int cyc;
      bit acc;
      total   = len + (TAIL ? M : 0);
      i       = 0;
      cyc     = 0;
      aborted = 1'b0;
      hs_count = 0;
      @(posedge clk); #1;
      start = 1'b1;
      payload_len = len[7:0];
      @(posedge clk); #1;
      start = 1'b0;
      while (i < len && cyc < 4000) begin
         start       = poke && (cyc == 3);
         payload_len = start ? 8'd0 : len[7:0];
         bit_valid   = 1'b1;
         bit_in      = u[i];
         @(negedge clk);
         if (cyc == 0) begin
            check("busy_on", busy, 1);
            check("frame_len", frame_len, total);
         end
         check("len_err_quiet", len_err, 0);
         if (abort_after > 0 && hs_count >= abort_after) begin
            aborted = 1'b1;
            break;
         end
         acc = bit_ready;
         if (acc) push_exp(i, total);
         @(posedge clk); #1;
         if (acc) i++;
         cyc++;
      end
      start     = 1'b0;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      if (aborted) return;
      check("bits_taken", i, len);
      if (TAIL) for (int t = len; t < total; t++) push_exp(t, total);
      cyc = 0;
      while (!frame_done && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
      check("done_seen", frame_done, 1);
      check("sb_drained", sb.size(), 0);
      check("busy_off", busy, 0);
      check("frame_len_held", frame_len, total);
   endtask

   task automatic len_err_case(input int len);
      @(posedge clk); #1;
      start = 1'b1;
      payload_len = len[7:0];
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("len_err_pulse", len_err, 1);
      check("busy_rejected", busy, 0);
      @(negedge clk);
      check("len_err_once", len_err, 0);
      check("busy_still_off", busy, 0);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("in_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_zero("post_rst");

      // Tail flush: 1,0,0,0 -> 11 11 10 11 11 00 00 00
      clear_u();
      u[0] = 1'b1;
      run_frame(4, 0, 1'b0, ab);
      check("st_zero_after_tail", dut.st, 0);

      // Impulse at bit 16, then again under random backpressure.
      clear_u();
      u[16] = 1'b1;
      run_frame(32, 0, 1'b0, ab);
      bp_on = 1'b1;
      run_frame(32, 0, 1'b0, ab);
      bp_on = 1'b0;

      len_err_case(252);
      len_err_case(0);

      // Largest legal frame, random data, stray start mid-frame.
      clear_u();
      for (int i = 0; i < 251; i++) u[i] = 1'($urandom_range(0, 1));
      bp_on = 1'b1;
      run_frame(251, 0, 1'b1, ab);
      bp_on = 1'b0;

      // Reset after ten symbols, then an all-zero frame.
      clear_u();
      for (int i = 0; i < 40; i++) u[i] = 1'($urandom_range(0, 1));
      run_frame(40, 10, 1'b0, ab);
      check("aborted", ab, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_zero("rst_mid");
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      check_zero("rst_mid_released");
      clear_u();
      run_frame(16, 0, 1'b0, ab);
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
